// File: rtl/dlfloat16_round_pack.sv
// DLFloat16 divider round/pack stage: RNE rounding, saturation, flush-to-zero, sticky flags.
// Optional DLF_ROUND_MODE_EN adds a 2-bit rnd_mode input (RNE/RTZ/RUP/RDN).
module dlfloat16_round_pack #(
  parameter int EXP_W  = 6,
  parameter int MAN_W  = 9,
  parameter int FLAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W+4:0]   in_data,
  input  logic [FLAG_W-1:0]        in_flags,
`ifdef DLF_ROUND_MODE_EN
  input  logic [1:0]               rnd_mode,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [FLAG_W-1:0]        out_flags,
  input  logic                     flags_clr,
  output logic [FLAG_W-1:0]        flags_sticky
);

  localparam int IN_W  = EXP_W + MAN_W + 5;
  localparam int OUT_W = EXP_W + MAN_W + 1;

  localparam logic [EXP_W-1:0]  E_MAX = '1;
  localparam logic [EXP_W-1:0]  E_SAT = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FLAG_W-1:0] F_NX  = FLAG_W'(8);
  localparam logic [FLAG_W-1:0] F_OF  = FLAG_W'(4);
  localparam logic [FLAG_W-1:0] F_UF  = FLAG_W'(2);

  logic              s1_v;
  logic [IN_W-1:0]   s1_d;
  logic [FLAG_W-1:0] s1_f;
`ifdef DLF_ROUND_MODE_EN
  logic [1:0]        s1_m;
`endif

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_d <= '0;
      s1_f <= '0;
`ifdef DLF_ROUND_MODE_EN
      s1_m <= 2'b00;
`endif
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_d <= in_data;
        s1_f <= in_flags;
`ifdef DLF_ROUND_MODE_EN
        s1_m <= rnd_mode;
`endif
      end
    end
  end

  logic             sgn;
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] frac;
  logic             g, r, st;
  logic             grs_nz;
  logic             mant_nz;
  logic             is_spec, is_zero, is_uf, is_norm;
  logic             inc;

  assign sgn     = s1_d[IN_W-1];
  assign e       = s1_d[IN_W-2 -: EXP_W];
  assign frac    = s1_d[MAN_W+2:3];
  assign g       = s1_d[2];
  assign r       = s1_d[1];
  assign st      = s1_d[0];
  assign grs_nz  = g | r | st;
  assign mant_nz = |s1_d[MAN_W+3:0];
  assign is_spec = (e == E_MAX);
  assign is_zero = (e == '0) && !mant_nz;
  assign is_uf   = (e == '0) && mant_nz;
  assign is_norm = !is_spec && (e != '0);

  always_comb begin
    inc = 1'b0;
`ifdef DLF_ROUND_MODE_EN
    unique case (s1_m)
      2'b00: inc = g & (r | st | frac[0]);
      2'b01: inc = 1'b0;
      2'b10: inc = !sgn & grs_nz;
      2'b11: inc = sgn & grs_nz;
    endcase
`else
    inc = g & (r | st | frac[0]);
`endif
  end

  logic [MAN_W:0]    sum;
  logic [EXP_W:0]    e_rnd;
  logic              sat;
  logic [OUT_W-1:0]  res_d;
  logic [FLAG_W-1:0] res_f;

  // Mantissa carry-out bumps the exponent; reaching all-ones means overflow
  assign sum   = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
  assign e_rnd = {1'b0, e} + {{EXP_W{1'b0}}, sum[MAN_W]};
  assign sat   = is_norm && (e_rnd == {1'b0, E_MAX});

  always_comb begin
    res_d = '0;
    res_f = s1_f;
    unique case (1'b1)
      is_spec: res_d = {sgn, E_MAX, frac};
      is_zero: res_d = {sgn, {(OUT_W-1){1'b0}}};
      is_uf: begin
        res_d = {sgn, {(OUT_W-1){1'b0}}};
        res_f = s1_f | F_UF | F_NX;
      end
      sat: begin
        res_d = {sgn, E_SAT, {MAN_W{1'b1}}};
        res_f = s1_f | F_OF | F_NX;
      end
      default: begin
        res_d = {sgn, e_rnd[EXP_W-1:0], sum[MAN_W-1:0]};
        res_f = s1_f | (grs_nz ? F_NX : '0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_data  <= res_d;
        out_flags <= res_f;
      end
    end
  end

  // Clear takes effect before the same-cycle handshake's flags are merged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_sticky <= '0;
    end else if (out_valid && out_ready) begin
      flags_sticky <= (flags_clr ? '0 : flags_sticky) | out_flags;
    end else if (flags_clr) begin
      flags_sticky <= '0;
    end
  end

endmodule

// File: tb/tb_dlfloat16_round_pack.sv
// Scoreboard bench for dlfloat16_round_pack.
// Honours DLF_ROUND_MODE_EN when the design is built with it.
module tb_dlfloat16_round_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic [4:0]  in_flags = '0;
  logic [1:0]  cur_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic        flags_clr = 1'b0;
  logic [4:0]  flags_sticky;

  int checks = 0;
  int errors = 0;

  logic [20:0] sb[$];
  logic [4:0]  exp_sticky = '0;
  logic        held_v = 1'b0;
  logic [15:0] held_d;
  logic [4:0]  held_f;

  dlfloat16_round_pack dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_flags(in_flags),
`ifdef DLF_ROUND_MODE_EN
    .rnd_mode(cur_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_flags(out_flags),
    .flags_clr(flags_clr),
    .flags_sticky(flags_sticky)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [19:0] d, input logic [4:0] fi,
                                input logic [1:0] mode,
                                output logic [15:0] od, output logic [4:0] fo);
    int e, q, rem;
    logic s, up;
    s   = d[19];
    e   = int'(d[18:13]);
    q   = int'(d[11:3]);
    rem = int'(d[2:0]);
    od  = '0;
    fo  = fi;
    if (e == 63) begin
      od = {s, 6'h3F, d[11:3]};
    end else if (e == 0) begin
      od = {s, 15'd0};
      if (d[12:0] != 13'd0) fo = fi | 5'b01010;
    end else begin
      up = (rem > 4) || (rem == 4 && (q % 2) == 1);
`ifdef DLF_ROUND_MODE_EN
      if (mode == 2'b01) up = 1'b0;
      if (mode == 2'b10) up = !s && rem != 0;
      if (mode == 2'b11) up = s && rem != 0;
`endif
      q = q + (up ? 1 : 0);
      if (q == 512) begin
        q = 0;
        e = e + 1;
      end
      if (e == 63) begin
        od = {s, 6'h3E, 9'h1FF};
        fo = fi | 5'b01100;
      end else begin
        od = {s, 6'(e), 9'(q)};
        if (rem != 0) fo = fi | 5'b01000;
      end
    end
  endfunction

  // Drives a transfer at a negedge; pushes the expectation on the accepting edge
  task automatic send(input logic [19:0] d, input logic [4:0] f,
                      input logic [15:0] ed, input logic [4:0] ef);
    logic hs;
    int tries;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_flags = f;
    forever begin
      #1;
      hs = in_ready;
      @(posedge clk);
      if (hs) begin
        sb.push_back({ed, ef});
        break;
      end
      tries++;
      if (tries > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", tries);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [19:0] d, input logic [4:0] f);
    logic [15:0] ed;
    logic [4:0]  ef;
    model(d, f, cur_mode, ed, ef);
    send(d, f, ed, ef);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      checks++;
      if (flags_sticky !== exp_sticky) begin
        errors++;
        $display("FAIL sticky: got %b, required %b", flags_sticky, exp_sticky);
      end
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_flags !== held_f) begin
          errors++;
          $display("FAIL hold: got v=%b %h/%b, required v=1 %h/%b",
                   out_valid, out_data, out_flags, held_d, held_f);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_f = out_flags;
      if (out_valid && out_ready) begin
        logic [20:0] e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h/%b, required none", out_data, out_flags);
          e = {out_data, out_flags};
        end else begin
          e = sb.pop_front();
          if ({out_data, out_flags} !== e) begin
            errors++;
            $display("FAIL result: got %h/%b, required %h/%b",
                     out_data, out_flags, e[20:5], e[4:0]);
          end
        end
        exp_sticky = (flags_clr ? 5'b0 : exp_sticky) | e[4:0];
      end else if (flags_clr) begin
        exp_sticky = 5'b0;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_flags !== 5'h0 ||
        flags_sticky !== 5'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h f=%b st=%b, required all 0",
               out_valid, out_data, out_flags, flags_sticky);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_spec_vectors();
    out_ready = 1'b1;
    send({1'b0, 6'd31, 1'b1, 9'h000, 3'b100}, 5'b0, 16'h3E00, 5'b01000);
    send({1'b0, 6'd31, 1'b1, 9'h001, 3'b100}, 5'b0, 16'h3E02, 5'b01000);
    send({1'b0, 6'd62, 1'b1, 9'h1FF, 3'b110}, 5'b0, 16'h7DFF, 5'b01100);
    send({1'b1, 6'd0,  1'b1, 9'h0A5, 3'b000}, 5'b0, 16'h8000, 5'b01010);
    send({1'b1, 6'd62, 1'b1, 9'h1FF, 3'b111}, 5'b0, 16'hFDFF, 5'b01100);
    send({1'b0, 6'd63, 1'b1, 9'h155, 3'b111}, 5'b10000, 16'h7F55, 5'b10000);
    send({1'b1, 6'd0,  1'b0, 9'h000, 3'b000}, 5'b00001, 16'h8000, 5'b00001);
    send({1'b0, 6'd31, 1'b1, 9'h1FF, 3'b100}, 5'b0, 16'h4000, 5'b01000);
    send({1'b0, 6'd31, 1'b1, 9'h0FF, 3'b011}, 5'b0, 16'h3EFF, 5'b01000);
    send({1'b0, 6'd40, 1'b1, 9'h123, 3'b000}, 5'b00001, 16'h5123, 5'b00001);
`ifdef DLF_ROUND_MODE_EN
    cur_mode = 2'b01;
    send({1'b0, 6'd31, 1'b1, 9'h001, 3'b100}, 5'b0, 16'h3E01, 5'b01000);
    cur_mode = 2'b10;
    send({1'b0, 6'd31, 1'b1, 9'h001, 3'b001}, 5'b0, 16'h3E02, 5'b01000);
    cur_mode = 2'b11;
    send({1'b1, 6'd31, 1'b1, 9'h001, 3'b001}, 5'b0, 16'hBE02, 5'b01000);
    cur_mode = 2'b00;
`endif
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_m({1'b0, 6'(20 + i), 1'b1, 9'(i * 37), 3'(i)}, 5'(i));
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || sb.size() != 2) begin
          errors++;
          $display("FAIL backpressure: in_ready=%b accepted=%0d, required 0 and 2",
                   in_ready, sb.size());
        end
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    #1;
    checks++;
    if (flags_sticky !== 5'b0) begin
      errors++;
      $display("FAIL sticky_clr_idle: got %b, required 00000", flags_sticky);
    end
    send({1'b0, 6'd31, 1'b1, 9'h000, 3'b000}, 5'b00100, 16'h3E00, 5'b00100);
    send({1'b0, 6'd31, 1'b1, 9'h000, 3'b000}, 5'b00010, 16'h3E00, 5'b00010);
    drain();
    @(negedge clk);
    #1;
    checks++;
    if (flags_sticky !== 5'b00110) begin
      errors++;
      $display("FAIL sticky_accum: got %b, required 00110", flags_sticky);
    end
    out_ready = 1'b0;
    send({1'b0, 6'd31, 1'b1, 9'h000, 3'b100}, 5'b0, 16'h3E00, 5'b01000);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    #1;
    checks++;
    if (flags_sticky !== 5'b01000) begin
      errors++;
      $display("FAIL sticky_clr_hs: got %b, required 01000", flags_sticky);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send_m({1'b0, 6'd10, 1'b1, 9'h0AA, 3'b101}, 5'b0);
    send_m({1'b1, 6'd11, 1'b1, 9'h055, 3'b011}, 5'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || flags_sticky !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b st=%b, required 0 and 00000",
               out_valid, flags_sticky);
    end
    sb.delete();
    exp_sticky = 5'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send({1'b0, 6'd33, 1'b1, 9'h010, 3'b000}, 5'b0, 16'h4210, 5'b0);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0",
               out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h4210) begin
      errors++;
      $display("FAIL latency: got v=%b d=%h, required 1 and 4210", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_m(20'($urandom), 5'($urandom));
    fork
      begin
        for (int i = 0; i < 24; i++) send_m(20'($urandom), 5'($urandom));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_sticky();
    test_reset_midstream();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
